otp_auth_fsm: RTL and testbench

Parametrised one-time-password authentication controller; successor to the fixed 4-digit OTP FSM. It latches an OTP from the LFSR generator and collects user digits, with optional digit clear. It compares the entry against the OTP and drives unlock, expiry and lockout indications to the display/actuator logic. New capabilities: configurable digit count, attempt limit and all hold/timeout durations; a user clear input; an explicit lockout state with a busy indication.

---
 rtl/otp_pkg.sv | 20 ++
 rtl/otp_hold_timer.sv | 28 ++
 rtl/otp_auth_fsm.sv | 198 +++++++++++++++++++
 tb/tb_otp_auth_fsm.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// Shared types and sizing helpers for the OTP authentication controller.
package otp_pkg;

  // Controller states; IDLE must stay at encoding zero.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_GEN         = 3'd1,
    ST_ENTER       = 3'd2,
    ST_CHECK       = 3'd3,
    ST_UNLOCK_HOLD = 3'd4,
    ST_EXPIRE_HOLD = 3'd5,
    ST_LOCKOUT     = 3'd6
  } state_e;

  // Bits needed for a down-counter whose largest load is n-1 (at least one bit).
  function automatic int cnt_w(input longint unsigned n);
    return (n < 64'd2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/otp_hold_timer.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module otp_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load takes priority over counting; the count never wraps below zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/otp_auth_fsm.sv
// One-time-password entry controller: latches a generated OTP, collects
// user digits, compares, and holds unlock / expired / locked indications.
module otp_auth_fsm
  import otp_pkg::*;
#(
  parameter int              DIGITS       = 4,
  parameter int              DIGIT_W      = 4,
  parameter int              MAX_ATTEMPTS = 3,
  parameter longint unsigned EXPIRE_CYC   = 64'd3_000_000_000,
  parameter longint unsigned HOLD_CYC     = 64'd500_000_000,
  parameter longint unsigned LOCKOUT_CYC  = 64'd500_000_000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DIGITS*DIGIT_W-1:0]           otp_in,
  input  logic                                otp_valid,
  input  logic [DIGIT_W-1:0]                  digit_in,
  input  logic                                digit_valid,
  input  logic                                clear_in,
  output logic                                unlock,
  output logic                                expired,
  output logic                                locked,
  output logic                                busy,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts,
  output logic [DIGITS*DIGIT_W-1:0]           entry_out,
  output logic [DIGITS*DIGIT_W-1:0]           otp_out
);

  localparam int              W        = DIGITS * DIGIT_W;
  localparam int              IW       = $clog2(DIGITS + 1);
  localparam int              AW       = $clog2(MAX_ATTEMPTS + 1);
  localparam int              EW       = cnt_w(EXPIRE_CYC);
  localparam longint unsigned HOLD_MAX = (HOLD_CYC > LOCKOUT_CYC) ? HOLD_CYC : LOCKOUT_CYC;
  localparam int              HW       = cnt_w(HOLD_MAX);

  localparam logic [EW-1:0] EXP_LOAD  = EW'(EXPIRE_CYC - 64'd1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 64'd1);
  localparam logic [HW-1:0] LOCK_LOAD = HW'(LOCKOUT_CYC - 64'd1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [AW-1:0] ATT_MAX   = AW'(MAX_ATTEMPTS);

  state_e               state_q;
  logic [W-1:0]         otp_q;
  logic [DIGIT_W-1:0]   entry_q [DIGITS];
  logic [IW-1:0]        idx_q;
  logic [AW-1:0]        attempts_q;

  logic [W-1:0]         entry_flat;
  logic                 match;
  logic [AW-1:0]        att_inc;

  logic                 exp_load, exp_en, exp_done;
  logic [EW-1:0]        exp_val;
  logic                 hold_load, hold_en, hold_done;
  logic [HW-1:0]        hold_val;

  // Digit 0 occupies the most-significant field of the flattened entry.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_flat
    assign entry_flat[(DIGITS-1-gi)*DIGIT_W +: DIGIT_W] = entry_q[gi];
  end

  assign match   = (entry_flat == otp_q);
  assign att_inc = attempts_q + AW'(1);

  // Timer control: expiry runs across ENTER and CHECK; the hold timer is
  // loaded on the same edge that moves into a hold/lockout state.
  always_comb begin
    exp_load  = 1'b0;
    exp_val   = '0;
    exp_en    = 1'b0;
    hold_load = 1'b0;
    hold_val  = '0;
    hold_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        exp_load  = 1'b1;
        hold_load = 1'b1;
      end
      ST_GEN: begin
        if (otp_valid) begin
          exp_load = 1'b1;
          exp_val  = EXP_LOAD;
        end
      end
      ST_ENTER: begin
        exp_en = 1'b1;
        if (exp_done) begin
          hold_load = 1'b1;
          hold_val  = HOLD_LOAD;
        end
      end
      ST_CHECK: begin
        exp_en = 1'b1;
        if (match) begin
          hold_load = 1'b1;
          hold_val  = HOLD_LOAD;
        end else if (att_inc == ATT_MAX) begin
          hold_load = 1'b1;
          hold_val  = LOCK_LOAD;
        end
      end
      ST_UNLOCK_HOLD, ST_EXPIRE_HOLD, ST_LOCKOUT: begin
        hold_en = 1'b1;
      end
      default: ;
    endcase
  end

  otp_hold_timer #(.W(EW)) u_expiry_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (exp_load),
    .load_val_i (exp_val),
    .en_i       (exp_en),
    .done_o     (exp_done)
  );

  otp_hold_timer #(.W(HW)) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (hold_load),
    .load_val_i (hold_val),
    .en_i       (hold_en),
    .done_o     (hold_done)
  );

  // Main controller: state, latched OTP, digit storage and attempt count.
  // Session data is also cleared on the way into IDLE so IDLE always
  // presents the same zeroed outputs as reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      otp_q      <= '0;
      idx_q      <= '0;
      attempts_q <= '0;
      for (int i = 0; i < DIGITS; i++) entry_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          otp_q      <= '0;
          idx_q      <= '0;
          attempts_q <= '0;
          for (int i = 0; i < DIGITS; i++) entry_q[i] <= '0;
          state_q    <= ST_GEN;
        end
        ST_GEN: begin
          if (otp_valid) begin
            otp_q   <= otp_in;
            state_q <= ST_ENTER;
          end
        end
        ST_ENTER: begin
          if (exp_done) begin
            state_q <= ST_EXPIRE_HOLD;
          end else if (clear_in) begin
            idx_q <= '0;
            for (int i = 0; i < DIGITS; i++) entry_q[i] <= '0;
          end else if (digit_valid) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (idx_q == IW'(i)) entry_q[i] <= digit_in;
            end
            idx_q <= idx_q + IW'(1);
            if (idx_q == LAST_IDX) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (match) begin
            state_q <= ST_UNLOCK_HOLD;
          end else begin
            attempts_q <= att_inc;
            idx_q      <= '0;
            for (int i = 0; i < DIGITS; i++) entry_q[i] <= '0;
            state_q    <= (att_inc == ATT_MAX) ? ST_LOCKOUT : ST_ENTER;
          end
        end
        ST_UNLOCK_HOLD, ST_EXPIRE_HOLD, ST_LOCKOUT: begin
          if (hold_done) begin
            otp_q      <= '0;
            idx_q      <= '0;
            attempts_q <= '0;
            for (int i = 0; i < DIGITS; i++) entry_q[i] <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign unlock    = (state_q == ST_UNLOCK_HOLD);
  assign expired   = (state_q == ST_EXPIRE_HOLD);
  assign locked    = (state_q == ST_LOCKOUT);
  assign busy      = (state_q != ST_IDLE);
  assign attempts  = attempts_q;
  assign entry_out = entry_flat;
  assign otp_out   = otp_q;

endmodule

// File: tb/tb_otp_auth_fsm.sv
// Directed bench for otp_auth_fsm with short timeouts.
module tb_otp_auth_fsm;

  logic        clk;
  logic        reset;
  logic [15:0] otp_in;
  logic        otp_valid;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        clear_in;
  logic        unlock, expired, locked, busy;
  logic [1:0]  attempts;
  logic [15:0] entry_out, otp_out;

  int n_cmp = 0;
  int n_bad = 0;

  otp_auth_fsm #(
    .DIGITS       (4),
    .DIGIT_W      (4),
    .MAX_ATTEMPTS (3),
    .EXPIRE_CYC   (64'd40),
    .HOLD_CYC     (64'd5),
    .LOCKOUT_CYC  (64'd8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .otp_in      (otp_in),
    .otp_valid   (otp_valid),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .clear_in    (clear_in),
    .unlock      (unlock),
    .expired     (expired),
    .locked      (locked),
    .busy        (busy),
    .attempts    (attempts),
    .entry_out   (entry_out),
    .otp_out     (otp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_otp(input logic [15:0] v);
    otp_in    = v;
    otp_valid = 1'b1;
    tick();
    otp_valid = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic send4(input logic [15:0] v);
    for (int i = 0; i < 4; i++) send_digit(v[15-4*i -: 4]);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    otp_in = '0; otp_valid = 0; digit_in = '0; digit_valid = 0; clear_in = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({unlock, expired, locked, busy} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {unlock, expired, locked, busy}); end
    n_cmp++; if ({attempts, entry_out, otp_out} !== 34'd0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", {attempts, entry_out, otp_out}); end
    reset = 1'b1;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_gen: busy got %b expected 1", busy); end
    $display("test_reset done");
  endtask

  task automatic test_unlock;
    int n;
    load_otp(16'h1234);
    n_cmp++; if (otp_out !== 16'h1234) begin n_bad++; $display("FAIL otp_latch: got %h expected 1234", otp_out); end
    send4(16'h1234);
    n_cmp++; if (unlock !== 1'b0) begin n_bad++; $display("FAIL unlock_early: got %b expected 0", unlock); end
    n_cmp++; if (entry_out !== 16'h1234) begin n_bad++; $display("FAIL entry_check: got %h expected 1234", entry_out); end
    tick();
    n_cmp++; if (unlock !== 1'b1) begin n_bad++; $display("FAIL unlock_start: got %b expected 1", unlock); end
    n_cmp++; if (attempts !== 2'd0) begin n_bad++; $display("FAIL unlock_attempts: got %0d expected 0", attempts); end
    n = 0;
    while (unlock === 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL unlock_len: got %0d expected 5", n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL unlock_idle: busy got %b expected 0", busy); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL unlock_regen: busy got %b expected 1", busy); end
    $display("test_unlock done");
  endtask

  task automatic test_retry;
    int n;
    load_otp(16'h1234);
    send4(16'h1235);
    tick();
    n_cmp++; if (attempts !== 2'd1) begin n_bad++; $display("FAIL retry_att1: got %0d expected 1", attempts); end
    n_cmp++; if (entry_out !== 16'h0000) begin n_bad++; $display("FAIL retry_entry_clr: got %h expected 0000", entry_out); end
    n_cmp++; if (unlock !== 1'b0) begin n_bad++; $display("FAIL retry_no_unlock: got %b expected 0", unlock); end
    send4(16'h1235);
    tick();
    n_cmp++; if (attempts !== 2'd2) begin n_bad++; $display("FAIL retry_att2: got %0d expected 2", attempts); end
    send4(16'h1234);
    n_cmp++; if (entry_out !== 16'h1234) begin n_bad++; $display("FAIL retry_entry_check: got %h expected 1234", entry_out); end
    tick();
    n_cmp++; if (unlock !== 1'b1) begin n_bad++; $display("FAIL retry_unlock: got %b expected 1", unlock); end
    n_cmp++; if (attempts !== 2'd2) begin n_bad++; $display("FAIL retry_att_hold: got %0d expected 2", attempts); end
    n = 0;
    while (unlock === 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++; if (attempts !== 2'd0) begin n_bad++; $display("FAIL retry_att_idle: got %0d expected 0", attempts); end
    tick();
    $display("test_retry done");
  endtask

  task automatic test_lockout;
    int n;
    load_otp(16'h1234);
    send4(16'h1111); tick();
    send4(16'h1111); tick();
    send4(16'h1111);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b expected 0", locked); end
    tick();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_start: got %b expected 1", locked); end
    n_cmp++; if (attempts !== 2'd3) begin n_bad++; $display("FAIL lock_att: got %0d expected 3", attempts); end
    n = 0;
    while (locked === 1'b1 && n < 50) begin
      digit_in = 4'h1; digit_valid = 1'b1;
      tick();
      n++;
    end
    digit_valid = 1'b0;
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL lock_len: got %0d expected 8", n); end
    n_cmp++; if (entry_out !== 16'h0000) begin n_bad++; $display("FAIL lock_digits_ignored: got %h expected 0000", entry_out); end
    n_cmp++; if ({busy, attempts} !== 3'b000) begin n_bad++; $display("FAIL lock_idle: busy/att got %b expected 000", {busy, attempts}); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lock_regen: busy got %b expected 1", busy); end
    $display("test_lockout done");
  endtask

  task automatic test_clear;
    int n;
    load_otp(16'h1234);
    send_digit(4'h1);
    send_digit(4'h2);
    n_cmp++; if (entry_out !== 16'h1200) begin n_bad++; $display("FAIL clear_partial: got %h expected 1200", entry_out); end
    clear_in = 1'b1; tick(); clear_in = 1'b0;
    n_cmp++; if (entry_out !== 16'h0000) begin n_bad++; $display("FAIL clear_zero: got %h expected 0000", entry_out); end
    clear_in = 1'b1; digit_in = 4'h7; digit_valid = 1'b1;
    tick();
    clear_in = 1'b0; digit_valid = 1'b0;
    n_cmp++; if (entry_out !== 16'h0000) begin n_bad++; $display("FAIL clear_priority: got %h expected 0000", entry_out); end
    send4(16'h1234);
    tick();
    n_cmp++; if (unlock !== 1'b1) begin n_bad++; $display("FAIL clear_unlock: got %b expected 1", unlock); end
    n_cmp++; if (attempts !== 2'd0) begin n_bad++; $display("FAIL clear_att: got %0d expected 0", attempts); end
    n = 0;
    while (unlock === 1'b1 && n < 50) begin tick(); n++; end
    tick();
    $display("test_clear done");
  endtask

  task automatic test_expire;
    int n;
    int m;
    load_otp(16'h5678);
    n = 0;
    while (expired !== 1'b1 && n < 100) begin
      if (n == 39) begin digit_in = 4'h9; digit_valid = 1'b1; end
      tick();
      digit_valid = 1'b0;
      n++;
    end
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL expire_cycle: got %0d expected 40", n); end
    n_cmp++; if (entry_out !== 16'h0000) begin n_bad++; $display("FAIL expire_digit_drop: got %h expected 0000", entry_out); end
    m = 0;
    while (expired === 1'b1 && m < 50) begin tick(); m++; end
    n_cmp++; if (m !== 5) begin n_bad++; $display("FAIL expire_len: got %0d expected 5", m); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL expire_idle: busy got %b expected 0", busy); end
    tick();
    $display("test_expire done");
  endtask

  task automatic test_reset_mid;
    load_otp(16'h1234);
    send4(16'h1234);
    tick();
    n_cmp++; if (unlock !== 1'b1) begin n_bad++; $display("FAIL mid_unlock: got %b expected 1", unlock); end
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if ({unlock, expired, locked, busy} !== 4'b0000) begin n_bad++; $display("FAIL mid_async_flags: got %b expected 0000", {unlock, expired, locked, busy}); end
    n_cmp++; if ({attempts, entry_out, otp_out} !== 34'd0) begin n_bad++; $display("FAIL mid_async_data: got %h expected 0", {attempts, entry_out, otp_out}); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if ({busy, unlock} !== 2'b10) begin n_bad++; $display("FAIL mid_gen: busy/unlock got %b expected 10", {busy, unlock}); end
    load_otp(16'hABCD);
    n_cmp++; if (otp_out !== 16'hABCD) begin n_bad++; $display("FAIL mid_new_otp: got %h expected abcd", otp_out); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_retry();
    test_lockout();
    test_clear();
    test_expire();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
